// File: rtl/gb_frame_writer.sv
// gb_frame_writer: turns the PPU pixel stream into RGB555 writes for a
// double-buffered 160x144 framebuffer. The front and back banks swap only
// while scanout is blanked, so scanout never shows a partly written frame.
module gb_frame_writer #(
  parameter logic [14:0] PAL0 = 15'h7FFF,
  parameter logic [14:0] PAL1 = 15'h56B5,
  parameter logic [14:0] PAL2 = 15'h294A,
  parameter logic [14:0] PAL3 = 15'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        lcd_on,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [1:0]  pix_shade,
  input  logic        disp_vblank,
  output logic        fb_we,
  output logic [14:0] fb_waddr,
  output logic [14:0] fb_wdata,
  output logic        fb_wbank,
  output logic        disp_bank,
  output logic        frame_done,
  output logic [1:0]  err_sticky
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITE     = 2'd1;
  localparam logic [1:0] ST_SWAP_WAIT = 2'd2;

  localparam logic [7:0] X_LAST = 8'd159;
  localparam logic [7:0] Y_LAST = 8'd143;

  logic [1:0]  state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [14:0] addr_q, addr_d;
  logic        pending_q, pending_d;
  logic        disp_bank_q, disp_bank_d;
  logic        fb_we_q, fb_we_d;
  logic [14:0] fb_waddr_q, fb_waddr_d;
  logic [14:0] fb_wdata_q, fb_wdata_d;
  logic        fb_wbank_q, fb_wbank_d;
  logic        frame_done_q, frame_done_d;
  logic [1:0]  err_q, err_d;

  logic [14:0] shade_rgb;
  logic [7:0]  x_base, y_base;
  logic [14:0] addr_base;

  // Fixed DMG shade-to-RGB555 palette lookup.
  always_comb begin
    unique case (pix_shade)
      2'd0:    shade_rgb = PAL0;
      2'd1:    shade_rgb = PAL1;
      2'd2:    shade_rgb = PAL2;
      default: shade_rgb = PAL3;
    endcase
  end

  // Next-state logic: raster counters, write generation, swap control, errors.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    pending_d    = pending_q;
    disp_bank_d  = disp_bank_q;
    err_d        = err_q;
    fb_we_d      = 1'b0;
    fb_waddr_d   = fb_waddr_q;
    fb_wdata_d   = fb_wdata_q;
    frame_done_d = 1'b0;
    x_base       = x_q;
    y_base       = y_q;
    addr_base    = addr_q;

    if (!lcd_on) begin
      // LCD off abandons the frame; the displayed bank is left alone.
      state_d   = ST_IDLE;
      pending_d = 1'b0;
      if (pix_valid) err_d[1] = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pix_valid) err_d[1] = 1'b1;
          if (frame_start) begin
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            state_d = ST_WRITE;
          end
        end

        ST_WRITE: begin
          // A restart mid-frame is a short frame: rewind, but keep writing so a
          // pixel arriving alongside the restart lands at address 0.
          if (frame_start) begin
            err_d[0]  = 1'b1;
            x_base    = '0;
            y_base    = '0;
            addr_base = '0;
          end
          x_d    = x_base;
          y_d    = y_base;
          addr_d = addr_base;
          if (pix_valid) begin
            fb_we_d    = 1'b1;
            fb_waddr_d = addr_base;
            fb_wdata_d = shade_rgb;
            if (x_base == X_LAST && y_base == Y_LAST) begin
              // Counters rewind so addr never reaches 23040.
              x_d     = '0;
              y_d     = '0;
              addr_d  = '0;
              state_d = ST_SWAP_WAIT;
            end else begin
              addr_d = addr_base + 15'd1;
              if (x_base == X_LAST) begin
                x_d = '0;
                y_d = y_base + 8'd1;
              end else begin
                x_d = x_base + 8'd1;
              end
            end
          end
        end

        ST_SWAP_WAIT: begin
          if (pix_valid) err_d[1] = 1'b1;
          if (frame_start) begin
            pending_d = 1'b1;
            x_d       = '0;
            y_d       = '0;
            addr_d    = '0;
          end
          if (disp_vblank) begin
            disp_bank_d  = ~disp_bank_q;
            frame_done_d = 1'b1;
            pending_d    = 1'b0;
            state_d      = (pending_q || frame_start) ? ST_WRITE : ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Write bank follows the back bank at the same edge disp_bank changes, so
    // the final pixel (written the cycle before) still lands on the old bank.
    fb_wbank_d = ~disp_bank_d;
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      pending_q    <= 1'b0;
      disp_bank_q  <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= '0;
      fb_wdata_q   <= '0;
      fb_wbank_q   <= 1'b1;
      frame_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      pending_q    <= pending_d;
      disp_bank_q  <= disp_bank_d;
      fb_we_q      <= fb_we_d;
      fb_waddr_q   <= fb_waddr_d;
      fb_wdata_q   <= fb_wdata_d;
      fb_wbank_q   <= fb_wbank_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_wdata   = fb_wdata_q;
  assign fb_wbank   = fb_wbank_q;
  assign disp_bank  = disp_bank_q;
  assign frame_done = frame_done_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_gb_frame_writer.sv
// tb_gb_frame_writer: directed vectors plus multi-cycle sequences for the
// frame writer (full frame, swap gating, back-to-back, short frame, LCD off,
// asynchronous reset).
module tb_gb_frame_writer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        lcd_on, frame_start, pix_valid, disp_vblank;
  logic [1:0]  pix_shade;
  logic        fb_we, fb_wbank, disp_bank, frame_done;
  logic [14:0] fb_waddr, fb_wdata;
  logic [1:0]  err_sticky;

  int checks = 0;
  int errors = 0;

  gb_frame_writer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .lcd_on      (lcd_on),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_shade   (pix_shade),
    .disp_vblank (disp_vblank),
    .fb_we       (fb_we),
    .fb_waddr    (fb_waddr),
    .fb_wdata    (fb_wdata),
    .fb_wbank    (fb_wbank),
    .disp_bank   (disp_bank),
    .frame_done  (frame_done),
    .err_sticky  (err_sticky)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        lcd;
    logic        fs;
    logic        pv;
    logic [1:0]  shade;
    logic        vb;
    logic        e_we;
    logic [14:0] e_waddr;
    logic [14:0] e_wdata;
    logic        e_wbank;
    logic        e_db;
    logic        e_fd;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [14:0] pal(input logic [1:0] s);
    case (s)
      2'd0:    pal = 15'h7FFF;
      2'd1:    pal = 15'h56B5;
      2'd2:    pal = 15'h294A;
      default: pal = 15'h0000;
    endcase
  endfunction

  // Outputs packed {we, waddr, wdata, wbank, disp_bank, frame_done}.
  function automatic logic [33:0] outs();
    outs = {fb_we, fb_waddr, fb_wdata, fb_wbank, disp_bank, frame_done};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    lcd_on = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    pix_shade = 2'd0; disp_vblank = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
  endtask

  // frame_start then n pixels of shade (x+y)%4; each write checked at N+1.
  task automatic run_pixels(input int n, input logic vb, input logic wbank,
                            input logic db, output logic [14:0] data161);
    data161 = '0;
    frame_start = 1'b1; pix_valid = 1'b0; disp_vblank = vb;
    step();
    frame_start = 1'b0;
    check("start_no_we", {63'd0, fb_we}, 64'd0);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = i % 160;
      y = i / 160;
      pix_valid = 1'b1;
      pix_shade = 2'((x + y) % 4);
      step();
      check($sformatf("pix%0d", i), {30'd0, outs()},
            {30'd0, 1'b1, 15'(i), pal(2'((x + y) % 4)), wbank, db, 1'b0});
      if (fb_waddr == 15'd161) data161 = fb_wdata;
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    logic [14:0] d161;
    Reset = 1'b1;
    idle_inputs();
    #12;
    check("reset_outs", {30'd0, outs()}, {30'd0, 1'b0, 15'd0, 15'd0, 1'b1, 1'b0, 1'b0});
    check("reset_err", {62'd0, err_sticky}, 64'd0);
    Reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    //            lcd fs  pv  sh    vb  we  waddr  wdata     wb  db  fd  err
    vecs[0]  = '{1'b1,1'b0,1'b1,2'd2,1'b0,1'b0,15'd0,15'h0000,1'b1,1'b0,1'b0,2'b10};
    vecs[1]  = '{1'b1,1'b1,1'b0,2'd0,1'b0,1'b0,15'd0,15'h0000,1'b1,1'b0,1'b0,2'b10};
    vecs[2]  = '{1'b1,1'b0,1'b1,2'd0,1'b0,1'b1,15'd0,15'h7FFF,1'b1,1'b0,1'b0,2'b10};
    vecs[3]  = '{1'b1,1'b0,1'b1,2'd1,1'b0,1'b1,15'd1,15'h56B5,1'b1,1'b0,1'b0,2'b10};
    vecs[4]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,15'd1,15'h56B5,1'b1,1'b0,1'b0,2'b10};
    vecs[5]  = '{1'b1,1'b0,1'b1,2'd3,1'b0,1'b1,15'd2,15'h0000,1'b1,1'b0,1'b0,2'b10};
    vecs[6]  = '{1'b1,1'b0,1'b1,2'd2,1'b0,1'b1,15'd3,15'h294A,1'b1,1'b0,1'b0,2'b10};
    vecs[7]  = '{1'b1,1'b1,1'b1,2'd1,1'b0,1'b1,15'd0,15'h56B5,1'b1,1'b0,1'b0,2'b11};
    vecs[8]  = '{1'b1,1'b0,1'b1,2'd0,1'b0,1'b1,15'd1,15'h7FFF,1'b1,1'b0,1'b0,2'b11};
    vecs[9]  = '{1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,15'd1,15'h7FFF,1'b1,1'b0,1'b0,2'b11};
    vecs[10] = '{1'b1,1'b0,1'b1,2'd3,1'b0,1'b0,15'd1,15'h7FFF,1'b1,1'b0,1'b0,2'b11};
    vecs[11] = '{1'b1,1'b1,1'b0,2'd0,1'b0,1'b0,15'd1,15'h7FFF,1'b1,1'b0,1'b0,2'b11};
    vecs[12] = '{1'b1,1'b0,1'b1,2'd3,1'b0,1'b1,15'd0,15'h0000,1'b1,1'b0,1'b0,2'b11};
    for (int i = 0; i < 13; i++) begin
      lcd_on = vecs[i].lcd; frame_start = vecs[i].fs; pix_valid = vecs[i].pv;
      pix_shade = vecs[i].shade; disp_vblank = vecs[i].vb;
      step();
      check($sformatf("vec%0d", i), {28'd0, outs(), err_sticky},
            {28'd0, vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_wbank,
             vecs[i].e_db, vecs[i].e_fd, vecs[i].e_err});
    end

    // ---------------- full frame, vblank high ----------------
    do_reset();
    run_pixels(23040, 1'b1, 1'b1, 1'b0, d161);
    check("addr161_pal2", {49'd0, d161}, {49'd0, 15'h294A});
    step();
    check("swap_edge", {62'd0, frame_done, disp_bank}, 64'b11);
    check("swap_wbank_we", {62'd0, fb_wbank, fb_we}, 64'b00);
    step();
    check("done_once", {62'd0, frame_done, disp_bank}, 64'b01);
    check("full_err", {62'd0, err_sticky}, 64'd0);

    // ------- swap gating + back-to-back start during SWAP_WAIT -------
    do_reset();
    run_pixels(23040, 1'b0, 1'b1, 1'b0, d161);
    for (int c = 0; c < 100; c++) begin
      frame_start = (c == 50);
      step();
      check($sformatf("gate%0d", c), {62'd0, disp_bank, frame_done}, 64'd0);
    end
    frame_start = 1'b0;
    disp_vblank = 1'b1;
    step();
    check("gate_swap", {62'd0, frame_done, disp_bank}, 64'b11);
    disp_vblank = 1'b0;
    pix_valid = 1'b1; pix_shade = 2'd1;
    step();
    pix_valid = 1'b0;
    check("b2b_first_write", {30'd0, outs()},
          {30'd0, 1'b1, 15'd0, 15'h56B5, 1'b0, 1'b1, 1'b0});
    check("b2b_err", {62'd0, err_sticky}, 64'd0);

    // ---------------- short frame then LCD off ----------------
    do_reset();
    run_pixels(5000, 1'b1, 1'b1, 1'b0, d161);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("short_err", {62'd0, err_sticky}, 64'b01);
    pix_valid = 1'b1; pix_shade = 2'd3;
    step();
    check("short_restart", {30'd0, outs()},
          {30'd0, 1'b1, 15'd0, 15'h0000, 1'b1, 1'b0, 1'b0});
    pix_shade = 2'd2;
    step();
    check("short_next", {49'd0, fb_waddr}, 64'd1);
    pix_valid = 1'b0; lcd_on = 1'b0;
    step();
    check("lcdoff", {61'd0, fb_we, frame_done, disp_bank}, 64'd0);
    lcd_on = 1'b1; pix_valid = 1'b1; pix_shade = 2'd0; disp_vblank = 1'b1;
    step();
    pix_valid = 1'b0;
    check("lcdoff_idle_drop", {61'd0, fb_we, err_sticky}, 64'b011);
    step();
    check("lcdoff_nodone", {62'd0, frame_done, disp_bank}, 64'd0);

    // ---------------- asynchronous reset mid-frame ----------------
    do_reset();
    run_pixels(12000, 1'b0, 1'b1, 1'b0, d161);
    pix_valid = 1'b1; pix_shade = 2'd3;
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset_outs", {30'd0, outs()}, {30'd0, 1'b0, 15'd0, 15'd0, 1'b1, 1'b0, 1'b0});
    check("async_reset_err", {62'd0, err_sticky}, 64'd0);
    pix_valid = 1'b0;
    #1;
    Reset = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid = 1'b1; pix_shade = 2'd1;
    step();
    pix_valid = 1'b0;
    check("post_reset_write", {30'd0, outs()},
          {30'd0, 1'b1, 15'd0, 15'h56B5, 1'b1, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gb_frame_writer.md
# gb_frame_writer

Writes the PPU's pixel stream into a double-buffered 160x144 RGB555 framebuffer. Each 2-bit DMG shade is converted to RGB555 through a fixed four-entry palette. The block tracks raster position and swaps the front/back banks only while the HDMI scanout is not fetching, so the scanout stage always reads a complete frame. It sits between the PPU pixel FIFO and the framebuffer BRAM write port; the scanout stage reads the bank selected by `disp_bank`.

## Interface

Parameters:
- `PAL0` — default 15'h7FFF — RGB555 colour for shade 0 (lightest).
- `PAL1` — default 15'h56B5 — RGB555 colour for shade 1.
- `PAL2` — default 15'h294A — RGB555 colour for shade 2.
- `PAL3` — default 15'h0000 — RGB555 colour for shade 3 (darkest).

Ports:
- `Clk` — in — 1 — single system clock; all logic on its rising edge.
- `Reset` — in — 1 — asynchronous, active-high reset.
- `lcd_on` — in — 1 — LCDC bit 7; low aborts any frame in progress.
- `frame_start` — in — 1 — one-cycle pulse from the PPU at the start of LY=0.
- `pix_valid` — in — 1 — a pixel is presented this cycle; no backpressure.
- `pix_shade` — in — 2 — DMG shade index 0..3.
- `disp_vblank` — in — 1 — high while the scanout stage is outside its fetch window.
- `fb_we` — out — 1 — framebuffer write enable.
- `fb_waddr` — out — 15 — write address within the bank, 0..23039.
- `fb_wdata` — out — 15 — RGB555 write data, {R[14:10], G[9:5], B[4:0]}.
- `fb_wbank` — out — 1 — bank being written; always `~disp_bank`.
- `disp_bank` — out — 1 — bank the scanout stage reads.
- `frame_done` — out — 1 — one-cycle pulse on the cycle `disp_bank` toggles.
- `err_sticky` — out — 2 — bit0 = short frame seen; bit1 = pixel dropped. Cleared only by `Reset`.

## Operation

- States:
  - IDLE: waiting for a frame.
  - WRITE: accepting pixels.
  - SWAP_WAIT: full frame written, waiting for scanout blanking.
- Counters:
  - `x` is 0..159 and `y` is 0..143.
  - `addr` is a running 15-bit counter equal to x+160*y. It increments by one per accepted pixel; the design uses no multiplier.
- IDLE:
  - `frame_start` with `lcd_on`=1 clears x, y and addr, then goes to WRITE.
  - A `pix_valid` in IDLE is dropped and sets `err_sticky[1]`.
- WRITE:
  - Each `pix_valid` is accepted and produces one write.
  - After the pixel at x=159, y=143, go to SWAP_WAIT.
  - `frame_start` in WRITE is a short frame:
    - Set `err_sticky[0]`.
    - Do not swap.
    - Clear the counters and stay in WRITE.
    - If `pix_valid` arrives on the same cycle, that pixel is written at address 0.
- SWAP_WAIT:
  - When `disp_vblank`=1, toggle `disp_bank` and pulse `frame_done`.
  - Then go to WRITE if a start is pending, otherwise to IDLE.
  - A `frame_start` seen in SWAP_WAIT sets a pending flag and clears the counters.
  - A `pix_valid` in SWAP_WAIT is dropped and sets `err_sticky[1]`, whether or not a start is pending.
- `lcd_on`=0 in any state:
  - Go to IDLE the next cycle.
  - Clear the pending flag.
  - Do not swap.
  - Leave `disp_bank` unchanged.
- Palette: shade n maps to `PALn`.

## Timing

- Reset values:
  - State = IDLE.
  - x = y = addr = 0.
  - `fb_we`=0, `fb_waddr`=0, `fb_wdata`=0.
  - `disp_bank`=0, so `fb_wbank`=1.
  - `frame_done`=0, `err_sticky`=0, pending flag = 0.
- Write latency:
  - A pixel accepted on edge N drives `fb_we`=1, `fb_waddr`, and `fb_wdata` (all registered) during cycle N+1.
  - `fb_we` deasserts in the next cycle unless another pixel is accepted.
- Throughput: one pixel per cycle, sustained.
- Wrap-around:
  - At x=159, x goes to 0 and y increments.
  - The final address is 23039; addr never reaches 23040.
- Bank swap:
  - The final pixel (addr 23039) is always committed to the old back bank.
  - `fb_wbank` is a registered copy of the bank captured with the write, so it does not toggle before the last write lands.
  - `disp_bank` toggles on the first edge where state = SWAP_WAIT and `disp_vblank`=1.
  - Minimum swap latency is 1 cycle after entering SWAP_WAIT.
- Simultaneous `frame_start` and `lcd_on`=0: `lcd_on`=0 wins and the state stays IDLE.
- Asynchronous `Reset` mid-frame: all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan

- **Full frame:** `frame_start`, then 23040 consecutive `pix_valid` with shade = (x+y)%4, with `disp_vblank`=1.
  - Required: 23040 writes with addresses 0..23039.
  - Addr 161 carries `PAL2`.
  - Exactly one `frame_done`, one cycle after the last write.
  - `disp_bank` goes from 0 to 1.
- **Swap gating:** as the full frame, but `disp_vblank`=0 for 100 cycles after the last pixel.
  - Required: `disp_bank` holds at 0 for those 100 cycles.
  - It toggles on the first edge with `disp_vblank`=1, with a single `frame_done` pulse.
- **Short frame:** `frame_start`, 5000 pixels, then `frame_start` again.
  - Required: `err_sticky`=2'b01.
  - The next write goes to address 0.
  - No `frame_done` and no bank change.
- **Back-to-back frames:** a second `frame_start` arrives during SWAP_WAIT.
  - Required: after the swap the state goes straight to WRITE.
  - The next write goes to address 0 on `fb_wbank`=0.
- **Drops and LCD off:** present `pix_valid` in IDLE; separately, deassert `lcd_on` mid-frame.
  - Required: `err_sticky[1]`=1 and no `fb_we`.
  - After `lcd_on` deasserts: IDLE next cycle, no `frame_done`, `disp_bank` unchanged.
- **Reset:** assert `Reset` asynchronously at addr 12000 during WRITE.
  - Required: all outputs return to their reset values before the next `Clk` edge.
  - A subsequent frame starts at address 0 with `fb_wbank`=1.
